nibble_serial_add_ctrl: RTL and testbench
=========================================

Name: nibble_serial_add_ctrl

Overview:
- Sequencing controller that runs WIDTH-bit add/subtract operations through one external 4-bit parallel adder slice.
- The slice is combinational, with ports A, B, Cin, Sum and Cout.
- The block processes one nibble per cycle, least significant first, and chains the carry between nibbles in a register.
- It sits between a valid/ready operand source and a valid/ready result sink, so a single narrow adder can serve wide arithmetic.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 8.
- NIB, WIDTH/4, number of nibbles (derived localparam, not overridable).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  controller can accept operands.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- op_cin  in  1  carry-in for add; ignored for sub.
- op_sub  in  1  0 = A+B+cin, 1 = A-B.
- add_a  out  4  nibble of A to the adder slice.
- add_b  out  4  nibble of effective B to the adder slice.
- add_cin  out  1  carry to the adder slice.
- add_sum  in  4  slice sum, combinational from add_a/add_b/add_cin.
- add_cout  in  1  slice carry-out.
- out_valid  out  1  result valid.
- out_ready  in  1  sink accepts result.
- res_sum  out  WIDTH  result.
- res_cout  out  1  final carry-out. For sub, 1 means no borrow.
- res_ovf  out  1  signed overflow.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Clock and reset: one clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - state = IDLE, nibble index = 0, carry register = 0, operand registers = 0.
  - res_sum = 0, res_cout = 0, res_ovf = 0.
  - out_valid = 0, busy = 0, in_ready = 1.
  - add_a/add_b/add_cin = 0.
- Reset may assert in any state. Any in-flight operation is discarded with no partial result and no out_valid pulse.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready at an edge:
    - latch op_a into a_reg.
    - latch op_sub ? ~op_b : op_b into b_reg.
    - set carry_reg = op_sub ? 1 : op_cin.
    - set index = 0.
    - go to RUN.
- RUN:
  - in_ready = 0.
  - Drive add_a = a_reg[4*idx+3:4*idx], add_b = b_reg[4*idx+3:4*idx], add_cin = carry_reg.
  - Each edge: res_sum[4*idx+3:4*idx] <= add_sum, carry_reg <= add_cout, idx <= idx+1.
  - On the edge where idx == NIB-1:
    - res_cout <= add_cout.
    - res_ovf <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) && (add_sum[3] != a_reg[WIDTH-1]).
    - go to DONE.
  - Index wrap: idx never exceeds NIB-1 and is reset to 0 on the next accept.
- DONE:
  - out_valid = 1, in_ready = 0.
  - res_* are held stable while out_valid && !out_ready.
  - On out_ready: go to IDLE, out_valid drops next cycle.
  - No back-to-back bypass: a new operand can be accepted at the earliest one cycle after result handoff.
- Latency: operands accepted at edge E; out_valid is visible after edge E+NIB (4 for WIDTH=16). Throughput is one operation per NIB+2 cycles.
- Outside RUN, add_a/add_b/add_cin are driven to 0.
- res_sum holds the last result in IDLE. It is overwritten nibble by nibble during RUN and is meaningful only while out_valid is high.
- in_valid is ignored whenever in_ready = 0. Operands are not required to stay stable after acceptance.
- Simultaneous events: out_ready together with a new in_valid in DONE accepts nothing that cycle. in_valid held high is accepted on the first IDLE cycle.
- Arithmetic is modulo 2^WIDTH. Subtraction is A + ~B + 1.

Test Plan:
- WIDTH=16, add: A=0x1234, B=0x5678, cin=0 -> res_sum=0x68AC, cout=0, ovf=0. out_valid exactly 4 cycles after accept. add_a sequence 4,3,2,1.
- Add with carry ripple: A=0xFFFF, B=0x0001, cin=0 -> res_sum=0x0000, cout=1, ovf=0. add_cin per nibble 0,1,1,1.
- Signed overflow: A=0x7FFF, B=0x0001 -> res_sum=0x8000, cout=0, ovf=1. Also A=0x7FFF, B=0x0000, cin=1 -> same result.
- Subtract: op_sub=1, A=0x0005, B=0x0007, op_cin=1 (ignored) -> res_sum=0xFFFE, cout=0. A=0x0007, B=0x0005 -> res_sum=0x0002, cout=1.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid high and new operands -> in_ready=0, res_* stable. After out_ready=1, the held operands are accepted on the first IDLE cycle.
- Reset mid-RUN: deassert rst_n after nibble 1 -> outputs return to reset values immediately. After release, the next operation 0x0001+0x0001 yields 0x0002 with no stale out_valid.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Sequencing controller that runs WIDTH-bit add/subtract operations one nibble per
// cycle, least significant first, through an external combinational 4-bit adder slice.
module nibble_serial_add_ctrl #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             op_cin,
   input  logic             op_sub,
   output logic [3:0]       add_a,
   output logic [3:0]       add_b,
   output logic             add_cin,
   input  logic [3:0]       add_sum,
   input  logic             add_cout,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] res_sum,
   output logic             res_cout,
   output logic             res_ovf,
   output logic             busy
);

   localparam int unsigned NIB   = WIDTH / 4;
   localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_reg;
   logic [WIDTH-1:0] b_reg;
   logic             carry_reg;

   logic [WIDTH-1:0] eff_b;
   logic             eff_cin;
   logic [IDX_W-1:0] nxt_idx;
   logic [3:0]       nxt_a;
   logic [3:0]       nxt_b;
   logic             is_last;

   // Slice operands are registered, so the nibble for the following cycle is
   // selected here one index ahead of the one currently presented.
   always_comb begin
      eff_b   = op_sub ? ~op_b : op_b;
      eff_cin = op_sub ? 1'b1 : op_cin;
      is_last = (idx == LAST_IDX);
      nxt_idx = is_last ? '0 : idx + 1'b1;
      nxt_a   = a_reg[{nxt_idx, 2'b00} +: 4];
      nxt_b   = b_reg[{nxt_idx, 2'b00} +: 4];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         carry_reg <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_ovf   <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         in_ready  <= 1'b1;
         add_a     <= '0;
         add_b     <= '0;
         add_cin   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_reg     <= op_a;
                  b_reg     <= eff_b;
                  carry_reg <= eff_cin;
                  idx       <= '0;
                  add_a     <= op_a[3:0];
                  add_b     <= eff_b[3:0];
                  add_cin   <= eff_cin;
                  in_ready  <= 1'b0;
                  busy      <= 1'b1;
                  state     <= RUN;
               end
            end

            RUN: begin
               res_sum[{idx, 2'b00} +: 4] <= add_sum;
               carry_reg <= add_cout;
               if (is_last) begin
                  res_cout  <= add_cout;
                  res_ovf   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                               (add_sum[3] != a_reg[WIDTH-1]);
                  add_a     <= '0;
                  add_b     <= '0;
                  add_cin   <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx     <= nxt_idx;
                  add_a   <= nxt_a;
                  add_b   <= nxt_b;
                  add_cin <= add_cout;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl with a behavioural 4-bit adder slice
// and a queue of expected results computed at full width.
module tb_nibble_serial_add_ctrl;

   localparam int unsigned WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             op_cin;
   logic             op_sub;
   logic [3:0]       add_a;
   logic [3:0]       add_b;
   logic             add_cin;
   logic [3:0]       add_sum;
   logic             add_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] res_sum;
   logic             res_cout;
   logic             res_ovf;
   logic             busy;

   typedef struct {
      logic [WIDTH-1:0] sum;
      logic             cout;
      logic             ovf;
   } exp_t;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   lat;
   int   waits;
   logic [3:0] seq_a[4];
   logic [3:0] seq_cin[4];
   logic [WIDTH-1:0] snap;

   nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op_a     (op_a),
      .op_b     (op_b),
      .op_cin   (op_cin),
      .op_sub   (op_sub),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_cin  (add_cin),
      .add_sum  (add_sum),
      .add_cout (add_cout),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .res_sum  (res_sum),
      .res_cout (res_cout),
      .res_ovf  (res_ovf),
      .busy     (busy)
   );

   // External combinational adder slice
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input logic sub);
      logic [WIDTH-1:0] be;
      logic             c;
      logic [WIDTH:0]   full;
      exp_t             e;
      be   = sub ? ~b : b;
      c    = sub ? 1'b1 : cin;
      full = {1'b0, a} + {1'b0, be} + {{WIDTH{1'b0}}, c};
      e.sum  = full[WIDTH-1:0];
      e.cout = full[WIDTH];
      e.ovf  = (a[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
      q.push_back(e);
      in_valid = 1'b1;
      op_a     = a;
      op_b     = b;
      op_cin   = cin;
      op_sub   = sub;
   endtask

   // Waits for acceptance; leaves the bench 1 time unit after the accepting edge.
   task automatic wait_accept(input string tag);
      logic got;
      got   = 1'b0;
      waits = 0;
      for (int i = 0; i < 20; i++) begin
         if (in_ready) begin
            @(posedge clk);
            #1;
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         waits++;
      end
      in_valid = 1'b0;
      op_a     = $urandom;
      op_b     = $urandom;
      chk({tag, "_accept"}, {31'b0, got}, 32'd1);
   endtask

   task automatic collect(input string tag);
      lat = 0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) break;
         if (i < 4) begin
            seq_a[i]   = add_a;
            seq_cin[i] = add_cin;
         end
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, "_latency"}, lat, 32'd4);
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      chk({tag, "_queue"}, q.size(), 32'd1);
      if (q.size() > 0) begin
         e = q.pop_front();
         chk({tag, "_sum"}, {16'b0, res_sum}, {16'b0, e.sum});
         chk({tag, "_cout"}, {31'b0, res_cout}, {31'b0, e.cout});
         chk({tag, "_ovf"}, {31'b0, res_ovf}, {31'b0, e.ovf});
      end
   endtask

   task automatic handoff(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_drop_valid"}, {31'b0, out_valid}, 32'd0);
      chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
   endtask

   task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin, input logic sub);
      drive(a, b, cin, sub);
      wait_accept(tag);
      collect(tag);
      check_result(tag);
      handoff(tag);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      op_a      = '0;
      op_b      = '0;
      op_cin    = 1'b0;
      op_sub    = 1'b0;
      #12;
      chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_res_sum", {16'b0, res_sum}, 32'd0);
      chk("rst_add_a", {28'b0, add_a}, 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Basic add with per-nibble slice operand sequence
      drive(16'h1234, 16'h5678, 1'b0, 1'b0);
      wait_accept("add1");
      chk("add1_busy", {31'b0, busy}, 32'd1);
      collect("add1");
      chk("add1_nib0_a", {28'b0, seq_a[0]}, 32'h4);
      chk("add1_nib1_a", {28'b0, seq_a[1]}, 32'h3);
      chk("add1_nib2_a", {28'b0, seq_a[2]}, 32'h2);
      chk("add1_nib3_a", {28'b0, seq_a[3]}, 32'h1);
      chk("add1_done_add_a", {28'b0, add_a}, 32'h0);
      check_result("add1");
      handoff("add1");

      // Carry ripple across all nibbles
      drive(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_accept("ripple");
      collect("ripple");
      chk("ripple_cin0", {28'b0, seq_cin[0]}, 32'd0);
      chk("ripple_cin1", {28'b0, seq_cin[1]}, 32'd1);
      chk("ripple_cin2", {28'b0, seq_cin[2]}, 32'd1);
      chk("ripple_cin3", {28'b0, seq_cin[3]}, 32'd1);
      check_result("ripple");
      handoff("ripple");

      run_op("ovf1", 16'h7FFF, 16'h0001, 1'b0, 1'b0);
      run_op("ovf2", 16'h7FFF, 16'h0000, 1'b1, 1'b0);
      run_op("sub1", 16'h0005, 16'h0007, 1'b1, 1'b1);
      run_op("sub2", 16'h0007, 16'h0005, 1'b0, 1'b1);
      run_op("subovf", 16'h8000, 16'h0001, 1'b0, 1'b1);
      run_op("addneg", 16'hA5C3, 16'h9E71, 1'b1, 1'b0);

      // Backpressure with new operands pending
      drive(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
      wait_accept("bp1");
      collect("bp1");
      check_result("bp1");
      snap = res_sum;
      drive(16'h2222, 16'h1111, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
         chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
         chk("bp_res_stable", {16'b0, res_sum}, {16'b0, snap});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp_no_bypass", {31'b0, busy}, 32'd0);
      chk("bp_in_ready_idle", {31'b0, in_ready}, 32'd1);
      wait_accept("bp2");
      chk("bp2_first_idle", waits, 32'd0);
      collect("bp2");
      check_result("bp2");
      handoff("bp2");

      // Reset during RUN discards the operation
      drive(16'hDEAD, 16'hBEEF, 1'b0, 1'b0);
      wait_accept("rstrun");
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      void'(q.pop_back());
      #1;
      chk("rstrun_in_ready", {31'b0, in_ready}, 32'd1);
      chk("rstrun_busy", {31'b0, busy}, 32'd0);
      chk("rstrun_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rstrun_res_sum", {16'b0, res_sum}, 32'd0);
      chk("rstrun_add_a", {28'b0, add_a}, 32'd0);
      chk("rstrun_add_cin", {31'b0, add_cin}, 32'd0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rstrun_no_stale", {31'b0, out_valid}, 32'd0);
      end
      run_op("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0);

      chk("queue_empty", q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
